// File: rtl/rv32i_pipe_core.sv
// Five-stage RV32I integer pipeline with on-chip instruction/data memories,
// full EX forwarding, a single-cycle load-use stall and EX-stage redirects.

module Rv32iImem #(
  parameter int WORDS = 1024
) (
  input  logic [$clog2(WORDS)-1:0] i_idx,
  output logic [31:0]              o_instr
);
  logic [31:0] mem [0:WORDS-1];

  assign o_instr = mem[i_idx];
endmodule

module Rv32iDmem #(
  parameter int WORDS = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(WORDS)-1:0] i_idx,
  input  logic                     i_we,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);
  logic [31:0] mem [0:WORDS-1];

  assign o_rdata = mem[i_idx];

  always_ff @(posedge clk) begin
    if (i_we) mem[i_idx] <= i_wdata;
  end
endmodule

module Rv32iRegFile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic [31:0] o_rs1Val,
  output logic [31:0] o_rs2Val,
  input  logic        i_we,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_wdata
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_we && i_rd != 5'd0) begin
      regs[i_rd] <= i_wdata;
    end
  end

  // Write-through: a same-cycle WB write is visible to the ID read.
  assign o_rs1Val = (i_rs1 == 5'd0) ? 32'd0 : (i_we && i_rd == i_rs1) ? i_wdata : regs[i_rs1];
  assign o_rs2Val = (i_rs2 == 5'd0) ? 32'd0 : (i_we && i_rd == i_rs2) ? i_wdata : regs[i_rs2];
endmodule

module rv32i_pipe_core #(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 1024
) (
  input logic clk,
  input logic rst_n
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } aluOp_t;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       useImm;
    logic       aPc;
    logic       aZero;
    aluOp_t     aluOp;
    logic [2:0] funct3;
  } ctrl_t;

  logic [31:0] r_pc;
  logic [31:0] r_ifidPc, r_ifidInstr;
  ctrl_t       r_idexCtrl;
  logic [31:0] r_idexPc, r_idexRs1Val, r_idexRs2Val, r_idexImm;
  logic [4:0]  r_idexRs1, r_idexRs2, r_idexRd;
  logic        r_exmemRegWrite, r_exmemMemRead, r_exmemMemWrite;
  logic [31:0] r_exmemResult, r_exmemStoreData;
  logic [4:0]  r_exmemRd;
  logic        r_memwbRegWrite;
  logic [31:0] r_memwbData;
  logic [4:0]  r_memwbRd;

  logic [31:0] w_imemInstr, w_dmemRdata, w_rs1Val, w_rs2Val;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_immI, w_immS, w_immB, w_immJ, w_immU, w_decImm;
  ctrl_t       w_decCtrl;
  aluOp_t      w_baseOp;
  logic        w_useRs1, w_useRs2, w_loadUse, w_stall, w_redirect, w_taken;
  logic [31:0] w_fwdA, w_fwdB, w_aluA, w_aluB, w_aluOut, w_exResult, w_target;

  Rv32iImem #(.WORDS(IMEM_WORDS)) INST1 (.i_idx(r_pc[IAW+1:2]), .o_instr(w_imemInstr));

  Rv32iDmem #(.WORDS(DMEM_WORDS)) DMEM (
    .clk(clk), .i_idx(r_exmemResult[DAW+1:2]), .i_we(r_exmemMemWrite),
    .i_wdata(r_exmemStoreData), .o_rdata(w_dmemRdata)
  );

  Rv32iRegFile RF (
    .clk(clk), .rst_n(rst_n), .i_rs1(w_rs1), .i_rs2(w_rs2),
    .o_rs1Val(w_rs1Val), .o_rs2Val(w_rs2Val),
    .i_we(r_memwbRegWrite), .i_rd(r_memwbRd), .i_wdata(r_memwbData)
  );

  assign w_opcode = r_ifidInstr[6:0];
  assign w_rd     = r_ifidInstr[11:7];
  assign w_funct3 = r_ifidInstr[14:12];
  assign w_rs1    = r_ifidInstr[19:15];
  assign w_rs2    = r_ifidInstr[24:20];
  assign w_funct7 = r_ifidInstr[31:25];
  assign w_immI = {{20{r_ifidInstr[31]}}, r_ifidInstr[31:20]};
  assign w_immS = {{20{r_ifidInstr[31]}}, r_ifidInstr[31:25], r_ifidInstr[11:7]};
  assign w_immB = {{19{r_ifidInstr[31]}}, r_ifidInstr[31], r_ifidInstr[7],
                   r_ifidInstr[30:25], r_ifidInstr[11:8], 1'b0};
  assign w_immJ = {{11{r_ifidInstr[31]}}, r_ifidInstr[31], r_ifidInstr[19:12],
                   r_ifidInstr[20], r_ifidInstr[30:21], 1'b0};
  assign w_immU = {r_ifidInstr[31:12], 12'd0};

  always_comb begin
    w_baseOp = ALU_ADD;
    case (w_funct3)
      3'b001:  w_baseOp = ALU_SLL;
      3'b010:  w_baseOp = ALU_SLT;
      3'b011:  w_baseOp = ALU_SLTU;
      3'b100:  w_baseOp = ALU_XOR;
      3'b101:  w_baseOp = ALU_SRL;
      3'b110:  w_baseOp = ALU_OR;
      3'b111:  w_baseOp = ALU_AND;
      default: w_baseOp = ALU_ADD;
    endcase
  end

  // Unrecognised encodings leave every control bit clear and so retire as NOPs.
  always_comb begin
    w_decCtrl = '0;
    w_decImm  = '0;
    w_useRs1  = 1'b0;
    w_useRs2  = 1'b0;
    w_decCtrl.funct3 = w_funct3;
    case (w_opcode)
      7'b0110011: begin
        if (w_funct7 == 7'h00) begin
          w_decCtrl.regWrite = 1'b1;
          w_decCtrl.aluOp    = w_baseOp;
        end else if (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
          w_decCtrl.regWrite = 1'b1;
          w_decCtrl.aluOp    = (w_funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end
        w_useRs1 = w_decCtrl.regWrite;
        w_useRs2 = w_decCtrl.regWrite;
      end
      7'b0010011: begin
        if (w_funct3 == 3'b001) begin
          w_decCtrl.regWrite = (w_funct7 == 7'h00);
          w_decCtrl.aluOp    = ALU_SLL;
        end else if (w_funct3 == 3'b101) begin
          w_decCtrl.regWrite = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
          w_decCtrl.aluOp    = (w_funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
        end else begin
          w_decCtrl.regWrite = 1'b1;
          w_decCtrl.aluOp    = w_baseOp;
        end
        w_decCtrl.useImm = w_decCtrl.regWrite;
        w_useRs1 = w_decCtrl.regWrite;
        w_decImm = w_immI;
      end
      7'b0000011: if (w_funct3 == 3'b010) begin
        w_decCtrl.regWrite = 1'b1;
        w_decCtrl.memRead  = 1'b1;
        w_decCtrl.useImm   = 1'b1;
        w_useRs1 = 1'b1;
        w_decImm = w_immI;
      end
      7'b0100011: if (w_funct3 == 3'b010) begin
        w_decCtrl.memWrite = 1'b1;
        w_decCtrl.useImm   = 1'b1;
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        w_decImm = w_immS;
      end
      7'b1100011: if (w_funct3 != 3'b010 && w_funct3 != 3'b011) begin
        w_decCtrl.branch = 1'b1;
        w_useRs1 = 1'b1;
        w_useRs2 = 1'b1;
        w_decImm = w_immB;
      end
      7'b1101111: begin
        w_decCtrl.regWrite = 1'b1;
        w_decCtrl.jal      = 1'b1;
        w_decImm = w_immJ;
      end
      7'b1100111: if (w_funct3 == 3'b000) begin
        w_decCtrl.regWrite = 1'b1;
        w_decCtrl.jalr     = 1'b1;
        w_useRs1 = 1'b1;
        w_decImm = w_immI;
      end
      7'b0110111: begin
        w_decCtrl.regWrite = 1'b1;
        w_decCtrl.aZero    = 1'b1;
        w_decCtrl.useImm   = 1'b1;
        w_decImm = w_immU;
      end
      7'b0010111: begin
        w_decCtrl.regWrite = 1'b1;
        w_decCtrl.aPc      = 1'b1;
        w_decCtrl.useImm   = 1'b1;
        w_decImm = w_immU;
      end
      default: ;
    endcase
  end

  assign w_loadUse = r_idexCtrl.memRead && (r_idexRd != 5'd0) &&
                     ((w_useRs1 && w_rs1 == r_idexRd) || (w_useRs2 && w_rs2 == r_idexRd));
  assign w_stall   = w_loadUse && !w_redirect;

  always_comb begin
    w_fwdA = r_idexRs1Val;
    w_fwdB = r_idexRs2Val;
    if (r_exmemRegWrite && r_exmemRd != 5'd0 && r_exmemRd == r_idexRs1)      w_fwdA = r_exmemResult;
    else if (r_memwbRegWrite && r_memwbRd != 5'd0 && r_memwbRd == r_idexRs1) w_fwdA = r_memwbData;
    if (r_exmemRegWrite && r_exmemRd != 5'd0 && r_exmemRd == r_idexRs2)      w_fwdB = r_exmemResult;
    else if (r_memwbRegWrite && r_memwbRd != 5'd0 && r_memwbRd == r_idexRs2) w_fwdB = r_memwbData;
  end

  assign w_aluA = r_idexCtrl.aZero ? 32'd0 : (r_idexCtrl.aPc ? r_idexPc : w_fwdA);
  assign w_aluB = r_idexCtrl.useImm ? r_idexImm : w_fwdB;

  always_comb begin
    w_aluOut = w_aluA + w_aluB;
    case (r_idexCtrl.aluOp)
      ALU_SUB:  w_aluOut = w_aluA - w_aluB;
      ALU_SLL:  w_aluOut = w_aluA << w_aluB[4:0];
      ALU_SLT:  w_aluOut = {31'd0, $signed(w_aluA) < $signed(w_aluB)};
      ALU_SLTU: w_aluOut = {31'd0, w_aluA < w_aluB};
      ALU_XOR:  w_aluOut = w_aluA ^ w_aluB;
      ALU_SRL:  w_aluOut = w_aluA >> w_aluB[4:0];
      ALU_SRA:  w_aluOut = $unsigned($signed(w_aluA) >>> w_aluB[4:0]);
      ALU_OR:   w_aluOut = w_aluA | w_aluB;
      ALU_AND:  w_aluOut = w_aluA & w_aluB;
      default:  w_aluOut = w_aluA + w_aluB;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_idexCtrl.funct3)
      3'b000:  w_taken = (w_fwdA == w_fwdB);
      3'b001:  w_taken = (w_fwdA != w_fwdB);
      3'b100:  w_taken = ($signed(w_fwdA) < $signed(w_fwdB));
      3'b101:  w_taken = ($signed(w_fwdA) >= $signed(w_fwdB));
      3'b110:  w_taken = (w_fwdA < w_fwdB);
      3'b111:  w_taken = (w_fwdA >= w_fwdB);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_redirect = (r_idexCtrl.branch && w_taken) || r_idexCtrl.jal || r_idexCtrl.jalr;
  assign w_target   = r_idexCtrl.jalr ? ((w_fwdA + r_idexImm) & ~32'd1) : (r_idexPc + r_idexImm);
  assign w_exResult = (r_idexCtrl.jal || r_idexCtrl.jalr) ? (r_idexPc + 32'd4) : w_aluOut;

  // Fetch side: redirect beats a load-use hold; flushed slots become NOPs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_ifidPc    <= '0;
      r_ifidInstr <= NOP;
    end else if (w_redirect) begin
      r_pc        <= w_target;
      r_ifidPc    <= '0;
      r_ifidInstr <= NOP;
    end else if (!w_stall) begin
      r_pc        <= r_pc + 32'd4;
      r_ifidPc    <= r_pc;
      r_ifidInstr <= w_imemInstr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idexCtrl <= '0; r_idexPc <= '0; r_idexRs1Val <= '0; r_idexRs2Val <= '0;
      r_idexImm <= '0; r_idexRs1 <= '0; r_idexRs2 <= '0; r_idexRd <= '0;
    end else if (w_redirect || w_stall) begin
      r_idexCtrl <= '0; r_idexPc <= '0; r_idexRs1Val <= '0; r_idexRs2Val <= '0;
      r_idexImm <= '0; r_idexRs1 <= '0; r_idexRs2 <= '0; r_idexRd <= '0;
    end else begin
      r_idexCtrl   <= w_decCtrl;
      r_idexPc     <= r_ifidPc;
      r_idexRs1Val <= w_rs1Val;
      r_idexRs2Val <= w_rs2Val;
      r_idexImm    <= w_decImm;
      r_idexRs1    <= w_useRs1 ? w_rs1 : 5'd0;
      r_idexRs2    <= w_useRs2 ? w_rs2 : 5'd0;
      r_idexRd     <= w_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exmemRegWrite <= 1'b0; r_exmemMemRead <= 1'b0; r_exmemMemWrite <= 1'b0;
      r_exmemResult <= '0; r_exmemStoreData <= '0; r_exmemRd <= '0;
      r_memwbRegWrite <= 1'b0; r_memwbData <= '0; r_memwbRd <= '0;
    end else begin
      r_exmemRegWrite  <= r_idexCtrl.regWrite;
      r_exmemMemRead   <= r_idexCtrl.memRead;
      r_exmemMemWrite  <= r_idexCtrl.memWrite;
      r_exmemResult    <= w_exResult;
      r_exmemStoreData <= w_fwdB;
      r_exmemRd        <= r_idexRd;
      r_memwbRegWrite  <= r_exmemRegWrite;
      r_memwbData      <= r_exmemMemRead ? w_dmemRdata : r_exmemResult;
      r_memwbRd        <= r_exmemRd;
    end
  end
endmodule

// File: tb/tb_rv32i_pipe_core.sv
// Directed program bench for rv32i_pipe_core: preloads small programs into
// INST1, runs them, and compares architectural state against hand-computed values.

module tb_rv32i_pipe_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rv32i_pipe_core #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (.clk(clk), .rst_n(rst_n));

  always #5 clk = ~clk;

  typedef struct {
    int          prog;
    int          regIdx;
    logic [31:0] expVal;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          stallCount = 0;
  logic [31:0] progMem [0:5][0:63];
  int          progLen [0:5];
  int          expStalls [0:5];
  vec_t        vecs [0:63];
  int          numVecs = 0;

  function automatic logic [31:0] encR(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] encI(int op, int f3, int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return encI(32'h13, 0, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] encSw(int rs2, int rs1, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] encB(int f3, int rs1, int rs2, int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] encJal(int rd, int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] encU(int op, int rd, int imm20);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction

  task automatic put(input int p, input logic [31:0] w);
    progMem[p][progLen[p]] = w;
    progLen[p]++;
  endtask

  task automatic addVec(input int p, input int r, input logic [31:0] e);
    vecs[numVecs] = '{prog: p, regIdx: r, expVal: e};
    numVecs++;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got %h, expected %h", name, idx, actual, expected);
    end
  endtask

  task automatic loadImem(input int p);
    for (int i = 0; i < 1024; i++) begin
      if (i < progLen[p]) dut.INST1.mem[i] = progMem[p][i];
      else                dut.INST1.mem[i] = 32'h0;
    end
  endtask

  task automatic applyStimulus(input int p, input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    loadImem(p);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    stallCount = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (dut.w_stall) stallCount++;
    end
  endtask

  task automatic buildPrograms();
    for (int p = 0; p < 6; p++) progLen[p] = 0;
    // 0: load-use
    put(0, addi(1, 0, 5)); put(0, encSw(1, 0, 0));
    put(0, encI(32'h03, 2, 2, 0, 0)); put(0, encR(0, 2, 2, 0, 3));
    // 1: forwarding chain
    put(1, addi(1, 0, 3)); put(1, addi(2, 1, 4));
    put(1, encR(0, 1, 2, 0, 3)); put(1, encR(32'h20, 2, 3, 0, 4));
    // 2: taken branch
    put(2, addi(1, 0, 1)); put(2, encB(0, 1, 1, 8));
    put(2, addi(5, 0, 99)); put(2, addi(6, 0, 7));
    // 3: x0 discard, JAL at 0x10
    put(3, addi(0, 0, 0)); put(3, addi(0, 0, 5)); put(3, encR(0, 0, 0, 0, 9));
    put(3, addi(0, 0, 0)); put(3, encJal(1, 8)); put(3, addi(7, 0, 55)); put(3, addi(8, 0, 9));
    // 4: ALU / branch / jump / store mix
    put(4, addi(1, 0, -8));               put(4, addi(2, 0, 3));
    put(4, encR(32'h20, 2, 1, 5, 3));     put(4, encR(0, 2, 1, 5, 4));
    put(4, encR(0, 2, 1, 2, 5));          put(4, encR(0, 2, 1, 3, 6));
    put(4, encR(0, 2, 1, 4, 7));          put(4, encI(32'h13, 1, 8, 2, 4));
    put(4, encU(32'h37, 9, 32'h12345));   put(4, encU(32'h17, 10, 1));
    put(4, encI(32'h13, 3, 11, 2, -1));   put(4, encI(32'h13, 7, 13, 1, 15));
    put(4, encB(4, 1, 2, 8));             put(4, addi(14, 0, 1));
    put(4, encB(6, 1, 2, 8));             put(4, addi(15, 0, 2));
    put(4, encI(32'h67, 0, 16, 0, 32'h4D)); put(4, addi(17, 0, 1));
    put(4, addi(17, 0, 2));               put(4, addi(18, 16, 1));
    put(4, encB(5, 2, 1, 8));             put(4, addi(19, 0, 1));
    put(4, encB(1, 2, 2, 8));             put(4, addi(20, 0, 3));
    put(4, encR(32'h20, 2, 0, 0, 21));    put(4, encR(0, 2, 2, 1, 22));
    put(4, encI(32'h13, 5, 23, 1, 32'h401)); put(4, addi(24, 0, 77));
    put(4, encSw(24, 0, 6));              put(4, encI(32'h03, 2, 25, 0, 4));
    put(4, encR(0, 0, 25, 0, 26));        put(4, encB(7, 1, 2, 8));
    put(4, addi(27, 0, 1));               put(4, encI(32'h13, 2, 28, 1, 0));
    put(4, encI(32'h13, 4, 29, 2, -1));   put(4, encR(0, 2, 1, 6, 12));
    put(4, encR(0, 1, 7, 7, 30));
    // 5: empty image (all words decode as NOP)
    expStalls[0] = 1; expStalls[1] = 0; expStalls[2] = 0;
    expStalls[3] = 0; expStalls[4] = 1; expStalls[5] = 0;
  endtask

  task automatic buildVectors();
    addVec(0, 1, 32'd5);  addVec(0, 2, 32'd5);  addVec(0, 3, 32'd10);
    addVec(1, 1, 32'd3);  addVec(1, 2, 32'd7);  addVec(1, 3, 32'd10); addVec(1, 4, 32'd3);
    addVec(2, 1, 32'd1);  addVec(2, 5, 32'd0);  addVec(2, 6, 32'd7);
    addVec(3, 0, 32'd0);  addVec(3, 9, 32'd0);  addVec(3, 1, 32'h14);
    addVec(3, 7, 32'd0);  addVec(3, 8, 32'd9);
    addVec(4, 3, 32'hFFFF_FFFF);  addVec(4, 4, 32'h1FFF_FFFF); addVec(4, 5, 32'd1);
    addVec(4, 6, 32'd0);          addVec(4, 7, 32'hFFFF_FFFB); addVec(4, 8, 32'h30);
    addVec(4, 9, 32'h1234_5000);  addVec(4, 10, 32'h1024);     addVec(4, 11, 32'd1);
    addVec(4, 13, 32'd8);         addVec(4, 14, 32'd0);        addVec(4, 15, 32'd2);
    addVec(4, 16, 32'h44);        addVec(4, 17, 32'd0);        addVec(4, 18, 32'h45);
    addVec(4, 19, 32'd0);         addVec(4, 20, 32'd3);        addVec(4, 21, 32'hFFFF_FFFD);
    addVec(4, 22, 32'd24);        addVec(4, 23, 32'hFFFF_FFFC); addVec(4, 25, 32'd77);
    addVec(4, 26, 32'd77);        addVec(4, 27, 32'd0);        addVec(4, 28, 32'd1);
    addVec(4, 29, 32'hFFFF_FFFC); addVec(4, 12, 32'hFFFF_FFFB); addVec(4, 30, 32'hFFFF_FFF8);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cur;
    logic [31:0] regOr;
    buildPrograms();
    buildVectors();

    // Reset state and first fetch from word 0 on an empty image.
    rst_n = 1'b0;
    loadImem(5);
    #20;
    checkOutput("pcInReset", 0, dut.r_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("pcAfterFirstEdge", 0, dut.r_pc, 32'd4);
    for (int c = 0; c < 10; c++) @(negedge clk);
    regOr = '0;
    for (int i = 0; i < 32; i++) regOr = regOr | dut.RF.regs[i];
    checkOutput("rfDrainZero", 0, regOr, 32'd0);

    // Table-driven program results.
    cur = -1;
    for (int i = 0; i < numVecs; i++) begin
      if (vecs[i].prog != cur) begin
        cur = vecs[i].prog;
        applyStimulus(cur, 80);
        checkOutput("stallCycles", cur, stallCount, expStalls[cur]);
      end
      checkOutput("reg", vecs[i].regIdx, dut.RF.regs[vecs[i].regIdx[4:0]], vecs[i].expVal);
    end
    checkOutput("dmemWord0", 0, dut.DMEM.mem[0], 32'd5);
    checkOutput("dmemWord1", 1, dut.DMEM.mem[1], 32'd77);

    // Reset pulsed mid-run clears state immediately, then the program reruns.
    applyStimulus(1, 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("pcMidReset", 0, dut.r_pc, 32'd0);
    checkOutput("rfMidReset", 3, dut.RF.regs[3], 32'd0);
    checkOutput("rfMidReset", 4, dut.RF.regs[4], 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) @(negedge clk);
    checkOutput("rerunReg", 4, dut.RF.regs[4], 32'd3);
    checkOutput("rerunReg", 2, dut.RF.regs[2], 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv32i_pipe_core.md
Name: rv32i_pipe_core

Overview:
Self-contained 5-stage (IF/ID/EX/MEM/WB) pipelined RV32I integer-subset processor. It has no functional I/O beyond clock and reset; programs are preloaded into instruction memory and results are checked hierarchically. It includes on-chip instruction memory, data memory, register file, full forwarding, load-use stall, and branch/jump flush.

Parameters:
IMEM_WORDS, 1024, instruction memory depth in 32-bit words.
DMEM_WORDS, 1024, data memory depth in 32-bit words.

Ports:
clk  input  1  system clock, rising-edge active (100 MHz nominal).
rst_n  input  1  asynchronous active-low reset.

Behaviour:
- Hierarchy contract for verification:
  - Instruction memory instance is named INST1 and holds array mem[0:IMEM_WORDS-1] of 32-bit words. Word index = PC[31:2] modulo IMEM_WORDS. Read is combinational. Loaded by $readmemh from index 0, one word per line.
  - Data memory instance is named DMEM with array mem[0:DMEM_WORDS-1]. Word index = addr[31:2] modulo DMEM_WORDS. Read is combinational; write is synchronous on the rising edge.
  - Register file instance is named RF with array regs[0:31].
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI.
  - Memory and control: LW, SW, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR, LUI, AUIPC.
  - Any other encoding executes as a NOP with no register or memory write.
- Reset (asynchronous, rst_n=0):
  - PC=0.
  - All pipeline registers hold a NOP with all control bits cleared.
  - RF regs cleared to 0.
  - DMEM and INST1 contents are not altered.
- Normal operation: one instruction fetched per cycle; PC+4 sequential fetch.
- Register file:
  - x0 always reads 0; writes to x0 are discarded.
  - A WB write and an ID read of the same register in the same cycle returns the new value (write-through bypass).
- Forwarding into EX operands, priority EX/MEM over MEM/WB.
  - Applies only when the producer writes a register and rd != 0.
  - Applies to store-data operands as well.
- Load-use hazard:
  - Trigger: the instruction in EX is LW with rd != 0, and the instruction in ID reads rs1 or rs2 == that rd.
  - Response: hold PC and IF/ID for one cycle and inject a bubble into ID/EX.
  - The dependent instruction then receives the value via MEM/WB forwarding.
  - Exactly one stall cycle per such hazard.
- Branch/jump handling:
  - Static predict-not-taken.
  - Branches and JALR are resolved in EX; JAL is also resolved in EX.
  - On redirect: PC <= target; IF/ID and ID/EX are flushed to NOPs, a 2-cycle penalty.
  - JAL/JALR write PC+4 to rd.
  - JALR target = (rs1+imm) & ~1.
  - Redirect takes priority over a simultaneous load-use stall.
- Arithmetic:
  - 32-bit wraparound with no exceptions.
  - Shifts use operand[4:0].
  - SLT is signed; SLTU is unsigned.
  - Immediates are sign-extended per RV32I formats.
- Misaligned LW/SW: low address bits are ignored (word access).
- Reset asserted mid-execution returns the core to the reset state immediately. Execution restarts at PC=0 on the first rising edge after release.

Test Plan:
- Reset, then release after 20 ns -> first fetch from word 0; all RF regs stay 0 while the pipeline drains NOPs.
- Load-use: ADDI x1,x0,5; SW x1,0(x0); LW x2,0(x0); ADD x3,x2,x2 -> DMEM.mem[0]=5, x2=5, x3=10, exactly one bubble cycle inserted.
- Forwarding chain: ADDI x1,x0,3; ADDI x2,x1,4; ADD x3,x2,x1; SUB x4,x3,x2 -> x1=3, x2=7, x3=10, x4=3, no stalls.
- Taken branch: ADDI x1,x0,1; BEQ x1,x1,+8; ADDI x5,x0,99; ADDI x6,x0,7 -> x5=0, x6=7.
- JAL x1,+8 at PC 0x10 -> x1=0x14; the skipped instruction does not write.
- ADDI x0,x0,5 -> x0 reads 0. Then pulse rst_n low mid-run -> PC returns to 0 and RF clears.
